// File: rtl/operand_fetch_cu.sv
// Operand fetch control unit: maps an A/B operand pair onto banked
// memories, splitting same-bank pairs into two consecutive issues.
module operand_fetch_cu #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned BANK_BITS = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        mode,
  input  logic [ADDR_W-1:0]           addr_a,
  input  logic [ADDR_W-1:0]           addr_b,
  output logic [(1<<BANK_BITS)-1:0]   mar_load,
  output logic [(1<<BANK_BITS)*ADDR_W-1:0] mar_in,
  output logic [(1<<BANK_BITS)-1:0]   mem_oe,
  output logic [(1<<BANK_BITS)-1:0]   mem_ld,
  output logic                        a_vld,
  output logic                        b_vld,
  output logic [BANK_BITS-1:0]        a_sel,
  output logic [BANK_BITS-1:0]        b_sel,
  output logic                        stall,
  input  logic                        clr_cnt,
  output logic [CNT_W-1:0]            conflict_cnt
);

  localparam int unsigned NB = 1 << BANK_BITS;

  typedef enum logic {
    S_RUN    = 1'b0,
    S_SECOND = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        eff_b;
  logic [BANK_BITS-1:0]     bank_a, bank_b, bank_l;
  logic                     accept, conflict;

  logic [NB-1:0]            mar_load_q, mar_load_d;
  logic [NB*ADDR_W-1:0]     mar_in_q, mar_in_d;
  logic                     a_vld_q, a_vld_d;
  logic                     b_vld_q, b_vld_d;
  logic [BANK_BITS-1:0]     a_sel_q, a_sel_d;
  logic [BANK_BITS-1:0]     b_sel_q, b_sel_d;
  logic                     stall_q, stall_d;
  logic [ADDR_W-1:0]        b_lat_q, b_lat_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  // Request decode: effective B, bank selects and conflict detection
  assign req_ready = (state_q == S_RUN);
  assign eff_b     = mode ? addr_b : addr_a + ADDR_W'(1);
  assign bank_a    = addr_a[BANK_BITS-1:0];
  assign bank_b    = eff_b[BANK_BITS-1:0];
  assign bank_l    = b_lat_q[BANK_BITS-1:0];
  assign accept    = req_valid & req_ready;
  assign conflict  = (bank_a == bank_b) && (addr_a != eff_b);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  // Next-state logic: a same-bank, different-address pair needs a second cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:    if (accept && conflict) state_d = S_SECOND;
      S_SECOND: state_d = S_RUN;
      default:  state_d = S_RUN;
    endcase
  end

  // Output logic: next values of the registered bank controls and counter
  always_comb begin
    mar_load_d = '0;
    mar_in_d   = mar_in_q;
    a_vld_d    = 1'b0;
    b_vld_d    = 1'b0;
    a_sel_d    = a_sel_q;
    b_sel_d    = b_sel_q;
    stall_d    = 1'b0;
    b_lat_d    = b_lat_q;
    cnt_d      = cnt_q;

    case (state_q)
      S_RUN: begin
        if (accept) begin
          for (int unsigned k = 0; k < NB; k++) begin
            if (BANK_BITS'(k) == bank_a) begin
              mar_load_d[k]                = 1'b1;
              mar_in_d[k*ADDR_W +: ADDR_W] = addr_a;
            end
            if (!conflict && BANK_BITS'(k) == bank_b) begin
              mar_load_d[k]                = 1'b1;
              mar_in_d[k*ADDR_W +: ADDR_W] = eff_b;
            end
          end
          a_vld_d = 1'b1;
          a_sel_d = bank_a;
          if (conflict) begin
            stall_d = 1'b1;
            b_lat_d = eff_b;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
          end else begin
            b_vld_d = 1'b1;
            b_sel_d = bank_b;
          end
        end
      end
      S_SECOND: begin
        for (int unsigned k = 0; k < NB; k++) begin
          if (BANK_BITS'(k) == bank_l) begin
            mar_load_d[k]                = 1'b1;
            mar_in_d[k*ADDR_W +: ADDR_W] = b_lat_q;
          end
        end
        b_vld_d = 1'b1;
        b_sel_d = bank_l;
        stall_d = 1'b1;
      end
      default: ;
    endcase

    // Clear wins over a coincident increment
    if (clr_cnt) cnt_d = '0;
  end

  // Output and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mar_load_q <= '0;
      mar_in_q   <= '0;
      a_vld_q    <= 1'b0;
      b_vld_q    <= 1'b0;
      a_sel_q    <= '0;
      b_sel_q    <= '0;
      stall_q    <= 1'b0;
      b_lat_q    <= '0;
      cnt_q      <= '0;
    end else begin
      mar_load_q <= mar_load_d;
      mar_in_q   <= mar_in_d;
      a_vld_q    <= a_vld_d;
      b_vld_q    <= b_vld_d;
      a_sel_q    <= a_sel_d;
      b_sel_q    <= b_sel_d;
      stall_q    <= stall_d;
      b_lat_q    <= b_lat_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mar_load     = mar_load_q;
  assign mem_oe       = mar_load_q;
  assign mem_ld       = '0;
  assign mar_in       = mar_in_q;
  assign a_vld        = a_vld_q;
  assign b_vld        = b_vld_q;
  assign a_sel        = a_sel_q;
  assign b_sel        = b_sel_q;
  assign stall        = stall_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: doc/operand_fetch_cu.md
OPERAND_FETCH_CU -- requirements
Module: operand_fetch_cu

Interface
REQ-001 SHALL provide parameter ADDR_W, default 4, operand address width in bits (>=2).
REQ-002 SHALL provide parameter BANK_BITS, default 1, bank-select bits; NB = 2**BANK_BITS banks, BANK_BITS < ADDR_W.
REQ-003 SHALL provide parameter CNT_W, default 8, conflict-counter width.
REQ-004 SHALL use one clock; reset is asynchronous and active-high; ports: clk in 1 rising-edge clock; rst in 1 async active-high reset.
REQ-005 SHALL have ports: req_valid in 1 request; req_ready out 1 accept-able; mode in 1 (0 = B is A+1, 1 = B explicit); addr_a in ADDR_W; addr_b in ADDR_W (used only when mode=1).
REQ-006 SHALL have ports: mar_load out NB per-bank MAR load; mar_in out NB*ADDR_W per-bank MAR value (bank k = slice k); mem_oe out NB per-bank read enable; mem_ld out NB per-bank write enable.
REQ-007 SHALL have ports: a_vld out 1 and b_vld out 1 operand-issued pulses; a_sel out BANK_BITS and b_sel out BANK_BITS bank carrying each operand; stall out 1; clr_cnt in 1; conflict_cnt out CNT_W.

Function
REQ-010 SHALL define bank(x) = x[BANK_BITS-1:0]; effective B = addr_b if mode=1, else (addr_a+1) mod 2**ADDR_W (wrap 1111 -> 0000).
REQ-011 SHALL run FSM states S_RUN and S_SECOND; req_ready = 1 in S_RUN only (combinational from state); acceptance = req_valid & req_ready at rising edge.
REQ-012 SHALL register all outputs except req_ready; mar_load, mem_oe, a_vld, b_vld, stall default to 0 each cycle unless set below; mar_in slices and a_sel/b_sel hold last value.
REQ-013 SHALL, on accept with bank(A) != bank(B), drive next cycle: mar_load, mem_oe = 1 on both banks, mar_in[bank(A)] = A, mar_in[bank(B)] = B, a_vld = b_vld = 1, a_sel = bank(A), b_sel = bank(B), stall = 0; state stays S_RUN (back-to-back accepts allowed).
REQ-014 SHALL, on accept with A == B (same address), issue once on bank(A) with a_vld = b_vld = 1, a_sel = b_sel = bank(A), stall = 0, no counter increment.
REQ-015 SHALL, on accept with bank(A) == bank(B) and A != B, drive next cycle: bank(A) load/oe, mar_in = A, a_vld = 1, a_sel = bank(A), stall = 1; latch B; go to S_SECOND.
REQ-016 SHALL, in S_SECOND, drive next cycle: bank(B) load/oe, mar_in = latched B, b_vld = 1, b_sel = bank(B), stall = 1; return to S_RUN; new inputs ignored in S_SECOND.
REQ-017 SHALL increment conflict_cnt by 1 on each REQ-015 accept, saturating at 2**CNT_W-1 (no wrap).
REQ-018 SHALL clear conflict_cnt to 0 on clr_cnt=1 at an edge; clr_cnt and increment in same cycle -> result 0.
REQ-019 SHALL hold mem_ld = 0 permanently (read-only fetch unit).
REQ-020 SHALL produce no output activity when no accept occurs in S_RUN (idle cycle: all pulses 0, stall 0).
REQ-021 SHALL issue A latency exactly 1 cycle after accept; B latency 1 cycle (no conflict) or 2 cycles (conflict).

Reset
REQ-030 SHALL, while rst=1, asynchronously force state S_RUN, all outputs 0 (mar_in, a_sel, b_sel, conflict_cnt included), latched B 0.
REQ-031 SHALL, on rst asserted in S_SECOND, abandon pending B (no b_vld after reset release); first edge after release may accept.

Verification
REQ-040 Defaults, mode=0, addr_a=0110 accepted -> next cycle mar_load=11, mar_in[0]=0110, mar_in[1]=0111, a_vld=b_vld=1, a_sel=0, b_sel=1, stall=0.
REQ-041 mode=0, addr_a=1111 -> B wraps to 0000; mar_in[1]=1111, mar_in[0]=0000, no stall.
REQ-042 mode=1, A=0010, B=0100 -> cycle1 bank0 mar_in=0010 a_vld stall=1, req_ready=0; cycle2 bank0 mar_in=0100 b_vld stall=1; cycle3 req_ready=1; conflict_cnt=1.
REQ-043 mode=1, A=B=0101 -> single issue bank1, a_vld=b_vld=1, stall=0, conflict_cnt unchanged.
REQ-044 CNT_W=2, four conflicting requests -> conflict_cnt 1,2,3,3; clr_cnt coincident with fifth conflict -> 0.
REQ-045 rst pulsed mid-cycle during S_SECOND -> outputs 0 immediately, no b_vld afterward, req_ready=1 after release.
